// File: rtl/mem_ctl.sv
// mem_ctl: single-port memory controller with a fixed wait-state count.
// Low addresses go to an external combinational ROM, all others to an
// internal RAM that aliases above its depth. Writes into ROM space are
// completed normally but flagged with a one-cycle fault pulse.
module mem_ctl #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 16,
    parameter int ROM_BITS = 8,
    parameter int RAM_BITS = 10,
    parameter int WAIT     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [WIDTH-1:0]    wdata,
    output logic                ready,
    output logic [WIDTH-1:0]    rdata,
    output logic                busy,
    output logic                fault,
    output logic [ROM_BITS-1:0] rom_addr,
    input  logic [WIDTH-1:0]    rom_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Counter start value on acceptance; unused when there are no wait states.
    localparam logic [3:0] WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WIDTH-1:0]    wdata_q;
    logic                ready_q;
    logic                busy_q;
    logic                fault_q;
    logic [WIDTH-1:0]    rdata_q;

    logic [WIDTH-1:0]    ram_q [0:(1 << RAM_BITS) - 1];

    logic                accept_d;
    logic                enterDone_d;
    logic                accWe_d;
    logic [ADDR_W-1:0]   accAddr_d;
    logic [WIDTH-1:0]    accWdata_d;
    logic                romSel_d;
    logic [RAM_BITS-1:0] ramIdx_d;

    // Decode the access that completes at the coming edge. With no wait
    // states the access finishes on its own accepting edge, so the live
    // inputs describe it; otherwise the latched copies do.
    always_comb begin
        accept_d    = req && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        enterDone_d = ((state_q == ST_WAIT) && (cnt_q == 4'd0)) ||
                      (accept_d && (WAIT == 0));
        if (WAIT == 0) begin
            accWe_d    = we;
            accAddr_d  = addr;
            accWdata_d = wdata;
        end else begin
            accWe_d    = we_q;
            accAddr_d  = addr_q;
            accWdata_d = wdata_q;
        end
        romSel_d = (accAddr_d[ADDR_W-1:ROM_BITS] == '0);
        ramIdx_d = accAddr_d[RAM_BITS-1:0];
    end

    // The ROM sees the latched address. A zero-wait read is sampled on the
    // same edge that latches its address, so the incoming address is
    // forwarded during that accepting cycle to keep rom_data in step.
    always_comb begin
        if ((WAIT == 0) && accept_d) begin
            rom_addr = addr[ROM_BITS-1:0];
        end else begin
            rom_addr = addr_q[ROM_BITS-1:0];
        end
    end

    // Access sequencer: accepts requests, counts wait states, and produces
    // the registered ready/fault pulses, busy flag and read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            if (enterDone_d) begin
                ready_q <= 1'b1;
                fault_q <= accWe_d && romSel_d;
                if (!accWe_d) begin
                    rdata_q <= romSel_d ? rom_data : ram_q[ramIdx_d];
                end
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        busy_q  <= 1'b1;
                        if (WAIT > 0) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WAIT_INIT;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // RAM array has no reset so its contents survive one; a write is
    // committed only on the edge that completes a RAM write, and never
    // while reset is held, so an aborted access leaves memory untouched.
    always_ff @(posedge clk) begin
        if (!reset && enterDone_d && accWe_d && !romSel_d) begin
            ram_q[ramIdx_d] <= accWdata_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign fault = fault_q;
    assign rdata = rdata_q;

endmodule
